// File: rtl/time_tmr_lock_voter.sv
// time_tmr_lock_voter: majority voter over three time-redundant copies sharing a group ID,
// with an arbiter lock while a group is open and an idle timeout that salvages two equal copies.
module time_tmr_lock_voter #(
  parameter int DataWidth   = 32,
  parameter int IDSize      = 4,
  parameter int LockTimeout = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 lock_o,
  output logic                 fault_detected_o
);
  localparam int IW = $clog2(LockTimeout + 1);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state, w_state_nx;
  logic [DataWidth-1:0] r_d0, r_d1, r_data, w_d0_nx, w_d1_nx, w_data_nx, w_maj;
  logic [IDSize-1:0] r_gid, r_last, w_gid_nx, w_last_nx;
  logic [IW-1:0] r_idle, w_idle_nx, w_inc;
  logic r_valid, r_fault, w_valid_nx, w_fault_nx, w_free, w_acc, w_to;
  assign w_free = ~r_valid | ready_i;
  assign w_acc = valid_i & w_free;
  assign w_maj = (r_d0 & r_d1) | (r_d0 & data_i) | (r_d1 & data_i);
  assign w_inc = (r_idle == IW'(LockTimeout)) ? r_idle : r_idle + 1'b1;
  assign w_to = w_inc == IW'(LockTimeout);
  assign ready_o = w_free;
  assign data_o = r_data;
  assign valid_o = r_valid;
  assign lock_o = r_state != EMPTY;
  assign fault_detected_o = r_fault;
  always_comb begin
    w_state_nx = r_state;
    w_d0_nx = r_d0;
    w_d1_nx = r_d1;
    w_gid_nx = r_gid;
    w_last_nx = r_last;
    w_idle_nx = r_idle;
    w_data_nx = r_data;
    w_valid_nx = r_valid & ~ready_i;
    w_fault_nx = 1'b0;
    if (!enable_i) begin
      w_state_nx = EMPTY;
      w_idle_nx = '0;
      if (w_acc) begin
        w_data_nx = data_i;
        w_valid_nx = 1'b1;
      end
    end else if (w_acc) begin
      w_idle_nx = '0;
      if (r_state == EMPTY) begin
        if (id_i != r_last) begin
          w_state_nx = ONE;
          w_d0_nx = data_i;
          w_gid_nx = id_i;
        end
      end else if (id_i != r_gid) begin
        w_fault_nx = 1'b1;
        w_state_nx = ONE;
        w_d0_nx = data_i;
        w_gid_nx = id_i;
      end else if (r_state == ONE) begin
        w_state_nx = TWO;
        w_d1_nx = data_i;
      end else begin
        w_state_nx = EMPTY;
        w_data_nx = w_maj;
        w_valid_nx = 1'b1;
        w_last_nx = r_gid;
        w_fault_nx = (r_d0 != r_d1) | (r_d0 != data_i);
      end
    end else if (r_state != EMPTY) begin
      if (!w_to) begin
        w_idle_nx = w_inc;
      end else if (r_state == TWO && r_d0 == r_d1) begin
        // two agreeing copies are still worth emitting, but only once the output slot is free
        w_idle_nx = w_free ? '0 : w_inc;
        if (w_free) begin
          w_state_nx = EMPTY;
          w_data_nx = r_d0;
          w_valid_nx = 1'b1;
          w_last_nx = r_gid;
          w_fault_nx = 1'b1;
        end
      end else begin
        w_state_nx = EMPTY;
        w_idle_nx = '0;
        w_fault_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EMPTY;
      r_d0 <= '0;
      r_d1 <= '0;
      r_gid <= '0;
      r_last <= '1;
      r_idle <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_d0 <= w_d0_nx;
      r_d1 <= w_d1_nx;
      r_gid <= w_gid_nx;
      r_last <= w_last_nx;
      r_idle <= w_idle_nx;
      r_data <= w_data_nx;
      r_valid <= w_valid_nx;
      r_fault <= w_fault_nx;
    end
  end
endmodule

// File: tb/tb_time_tmr_lock_voter.sv
// tb_time_tmr_lock_voter: directed scenarios plus randomized traffic checked against a
// queue-based behavioural model of the voter.
module tb_time_tmr_lock_voter;
  localparam int LT = 5;
  logic clk_i = 1'b0, rst_i = 1'b1, enable_i = 1'b1, valid_i = 1'b0, ready_i = 1'b1;
  logic [7:0] data_i = '0;
  logic [3:0] id_i = '0;
  logic ready_o, valid_o, lock_o, fault_detected_o;
  logic [7:0] data_o;
  int n_vec = 0, n_bad = 0;
  logic [7:0] q[$];
  logic [3:0] m_gid, m_last;
  int m_idle;
  logic m_vo, m_f;
  logic [7:0] m_do;

  time_tmr_lock_voter #(.DataWidth(8), .IDSize(4), .LockTimeout(LT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i), .id_i(id_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .lock_o(lock_o), .fault_detected_o(fault_detected_o));

  always #5 clk_i = ~clk_i;

  task automatic m_reset();
    q.delete();
    m_gid = '0;
    m_last = 4'hF;
    m_idle = 0;
    m_vo = 1'b0;
    m_f = 1'b0;
    m_do = '0;
  endtask

  // One clock of the voter rules: copies of the open group live in a queue.
  task automatic model(input logic en, input logic [7:0] d, input logic [3:0] id, input logic v, input logic rdy);
    logic free, acc;
    logic [7:0] a, b, maj;
    int c;
    free = !m_vo || rdy;
    acc = v && free;
    if (m_vo && rdy) m_vo = 1'b0;
    m_f = 1'b0;
    if (!en) begin
      q.delete();
      m_idle = 0;
      if (acc) begin m_vo = 1'b1; m_do = d; end
    end else if (acc) begin
      m_idle = 0;
      if (q.size() == 0) begin
        if (id != m_last) begin q.push_back(d); m_gid = id; end
      end else if (id != m_gid) begin
        m_f = 1'b1; q.delete(); q.push_back(d); m_gid = id;
      end else if (q.size() == 1) begin
        q.push_back(d);
      end else begin
        a = q[0]; b = q[1];
        for (int k = 0; k < 8; k++) begin
          c = int'(a[k]) + int'(b[k]) + int'(d[k]);
          maj[k] = c >= 2;
        end
        m_vo = 1'b1; m_do = maj; m_f = !(a == b && b == d); m_last = m_gid; q.delete();
      end
    end else if (q.size() != 0) begin
      if (m_idle < LT) m_idle++;
      if (m_idle == LT) begin
        if (q.size() == 2 && q[0] == q[1]) begin
          if (free) begin m_vo = 1'b1; m_do = q[0]; m_f = 1'b1; m_last = m_gid; q.delete(); m_idle = 0; end
        end else begin
          m_f = 1'b1; q.delete(); m_idle = 0;
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic [3:0] id, input logic v, input logic rdy);
    enable_i = en; data_i = d; id_i = id; valid_i = v; ready_i = rdy;
    @(posedge clk_i);
    model(en, d, id, v, rdy);
    #1;
  endtask

  task automatic test_reset();
    valid_i = 1'b1; data_i = 8'hFF;
    #3;
    n_vec++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || lock_o !== 1'b0 || fault_detected_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_state valid=%b data=%h lock=%b fault=%b ready=%b, need 0 00 0 0 1", valid_o, data_o, lock_o, fault_detected_o, ready_o);
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (valid_o !== 1'b0 || lock_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold valid=%b lock=%b, need 0 0", valid_o, lock_o);
    end
    m_reset();
    @(negedge clk_i); rst_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic test_clean();
    step(1, 8'hA5, 4'd1, 1, 1);
    n_vec++; if (lock_o !== 1'b1) begin n_bad++; $display("FAIL clean_lock1 got %b need 1", lock_o); end
    step(1, 8'hA5, 4'd1, 1, 1);
    n_vec++; if (lock_o !== 1'b1 || valid_o !== 1'b0) begin n_bad++; $display("FAIL clean_lock2 lock=%b valid=%b need 1 0", lock_o, valid_o); end
    step(1, 8'hA5, 4'd1, 1, 1);
    n_vec++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5 || lock_o !== 1'b0 || fault_detected_o !== 1'b0) begin
      n_bad++; $display("FAIL clean_vote valid=%b data=%h lock=%b fault=%b need 1 a5 0 0", valid_o, data_o, lock_o, fault_detected_o);
    end
    step(1, 8'h00, 4'd0, 0, 1);
    n_vec++; if (valid_o !== 1'b0 || fault_detected_o !== 1'b0) begin n_bad++; $display("FAIL clean_drain valid=%b fault=%b need 0 0", valid_o, fault_detected_o); end
  endtask

  task automatic test_upset();
    logic [7:0] beats [3] = '{8'hF0, 8'hF1, 8'hF0};
    int nf = 0;
    foreach (beats[k]) begin step(1, beats[k], 4'd2, 1, 1); nf += int'(fault_detected_o); end
    n_vec++; if (valid_o !== 1'b1 || data_o !== 8'hF0) begin n_bad++; $display("FAIL upset_vote valid=%b data=%h need 1 f0", valid_o, data_o); end
    for (int k = 0; k < 2; k++) begin step(1, 8'h00, 4'd0, 0, 1); nf += int'(fault_detected_o); end
    n_vec++; if (nf != 1) begin n_bad++; $display("FAIL upset_fault_pulses got %0d need 1", nf); end
  endtask

  task automatic test_timeout();
    int found = 0;
    logic [7:0] got = '0;
    logic f_at = 1'b0, l_at = 1'b1;
    step(1, 8'h11, 4'd3, 1, 1);
    step(1, 8'h11, 4'd3, 1, 1);
    for (int k = 1; k <= 10 && found == 0; k++) begin
      step(1, 8'h00, 4'd0, 0, 1);
      if (valid_o === 1'b1) begin found = k; got = data_o; f_at = fault_detected_o; l_at = lock_o; end
    end
    n_vec++; if (found != LT) begin n_bad++; $display("FAIL timeout_latency got %0d idle cycles need %0d", found, LT); end
    n_vec++; if (got !== 8'h11 || f_at !== 1'b1 || l_at !== 1'b0) begin n_bad++; $display("FAIL timeout_emit data=%h fault=%b lock=%b need 11 1 0", got, f_at, l_at); end
  endtask

  task automatic test_mismatch();
    int nf = 0, ne = 0;
    logic [7:0] got = '0;
    step(1, 8'h22, 4'd4, 1, 1); nf += int'(fault_detected_o);
    for (int k = 0; k < 3; k++) begin
      step(1, 8'h33, 4'd5, 1, 1); nf += int'(fault_detected_o);
      if (valid_o === 1'b1) begin ne++; got = data_o; end
    end
    step(1, 8'h33, 4'd5, 1, 1); nf += int'(fault_detected_o);
    n_vec++; if (lock_o !== 1'b0) begin n_bad++; $display("FAIL mismatch_stale_lock got %b need 0", lock_o); end
    step(1, 8'h00, 4'd0, 0, 1); nf += int'(fault_detected_o);
    if (valid_o === 1'b1) ne++;
    n_vec++; if (ne != 1 || got !== 8'h33) begin n_bad++; $display("FAIL mismatch_emit count=%0d data=%h need 1 33", ne, got); end
    n_vec++; if (nf != 1) begin n_bad++; $display("FAIL mismatch_fault_pulses got %0d need 1", nf); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) step(1, 8'h44, 4'd6, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 8'h66, 4'd7, 1, 0);
      n_vec++;
      if (valid_o !== 1'b1 || data_o !== 8'h44 || ready_o !== 1'b0 || lock_o !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d valid=%b data=%h ready=%b lock=%b need 1 44 0 0", k, valid_o, data_o, ready_o, lock_o);
      end
    end
    step(1, 8'h66, 4'd7, 1, 1);
    n_vec++; if (valid_o !== 1'b0 || lock_o !== 1'b1) begin n_bad++; $display("FAIL bp_release valid=%b lock=%b need 0 1", valid_o, lock_o); end
    step(1, 8'h66, 4'd7, 1, 1);
    step(1, 8'h66, 4'd7, 1, 1);
    n_vec++; if (valid_o !== 1'b1 || data_o !== 8'h66) begin n_bad++; $display("FAIL bp_second valid=%b data=%h need 1 66", valid_o, data_o); end
    step(1, 8'h00, 4'd0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [2] = '{8'h5A, 8'hC3};
    logic [3:0] ids [2] = '{4'd10, 4'd11};
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready g%0d b%0d got %b need 1", g, k, ready_o); end
        step(1, vals[g], ids[g], 1, 1);
      end
      n_vec++; if (valid_o !== 1'b1 || data_o !== vals[g]) begin n_bad++; $display("FAIL b2b_vote g%0d valid=%b data=%h need 1 %h", g, valid_o, data_o, vals[g]); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 8'h77, 4'd8, 1, 1);
    step(1, 8'h77, 4'd8, 1, 1);
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_vec++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || lock_o !== 1'b0 || fault_detected_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++; $display("FAIL midreset valid=%b data=%h lock=%b fault=%b ready=%b need 0 00 0 0 1", valid_o, data_o, lock_o, fault_detected_o, ready_o);
    end
    m_reset();
    @(negedge clk_i); rst_i = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 8'h55, 4'd0, 1, 1);
    n_vec++; if (valid_o !== 1'b1 || data_o !== 8'h55 || fault_detected_o !== 1'b0) begin n_bad++; $display("FAIL midreset_next valid=%b data=%h fault=%b need 1 55 0", valid_o, data_o, fault_detected_o); end
  endtask

  task automatic test_passthrough();
    int nf = 0;
    step(1, 8'h99, 4'd9, 1, 1);
    step(0, 8'h12, 4'd9, 1, 1); nf += int'(fault_detected_o);
    n_vec++; if (valid_o !== 1'b1 || data_o !== 8'h12 || lock_o !== 1'b0) begin n_bad++; $display("FAIL pass_first valid=%b data=%h lock=%b need 1 12 0", valid_o, data_o, lock_o); end
    step(0, 8'h34, 4'd2, 1, 1); nf += int'(fault_detected_o);
    n_vec++; if (valid_o !== 1'b1 || data_o !== 8'h34) begin n_bad++; $display("FAIL pass_second valid=%b data=%h need 1 34", valid_o, data_o); end
    step(0, 8'h00, 4'd0, 0, 1); nf += int'(fault_detected_o);
    n_vec++; if (nf != 0 || valid_o !== 1'b0) begin n_bad++; $display("FAIL pass_quiet faults=%0d valid=%b need 0 0", nf, valid_o); end
  endtask

  task automatic test_random();
    logic [7:0] base = 8'h3C, d;
    logic [3:0] cid = 4'd1;
    logic en, v, rdy;
    int busy;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      busy = ((cyc / 100) % 2 == 0) ? 85 : 25;
      if ($urandom_range(0, 7) == 0) base = 8'($urandom);
      if ($urandom_range(0, 5) == 0) cid = 4'($urandom_range(0, 3));
      d = base ^ (($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      en = $urandom_range(0, 24) != 0;
      v = $urandom_range(0, 99) < busy;
      rdy = $urandom_range(0, 3) != 0;
      step(en, d, cid, v, rdy);
      n_vec++;
      if (valid_o !== m_vo || fault_detected_o !== m_f || lock_o !== (q.size() != 0) || ready_o !== (!m_vo || rdy) || (m_vo && data_o !== m_do)) begin
        n_bad++;
        $display("FAIL random cyc=%0d valid=%b/%b data=%h/%h fault=%b/%b lock=%b/%b ready=%b/%b (got/need)", cyc,
                 valid_o, m_vo, data_o, m_do, fault_detected_o, m_f, lock_o, q.size() != 0, ready_o, !m_vo || rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_upset();
    test_timeout();
    test_mismatch();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
